// File: rtl/exu_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3
// encodings of the RV M-extension, FSM state encoding and a decode helper.
package exu_mdu_pkg;

  localparam int MDU_FUNCT_WIDTH = 3;

  // RV funct3 encodings for the M-extension operations
  typedef enum logic [MDU_FUNCT_WIDTH-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_funct_e;

  // Iteration state machine
  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Decode flag: the instruction belongs to this unit rather than the ALU
  function automatic logic is_mdu(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/exu_mdu_fixup.sv
// Sign correction of the unsigned iteration results. Selects product half,
// quotient or remainder and applies two's complement negation at full width.
module exu_mdu_fixup
  import exu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          prod_i,
  input  logic [XLEN-1:0]            quo_i,
  input  logic [XLEN-1:0]            rem_i,
  input  logic                       neg_res_i,
  input  logic                       neg_rem_i,
  input  logic [MDU_FUNCT_WIDTH-1:0] funct_i,
  output logic [XLEN-1:0]            result_o
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Negate where the latched sign flags say so, then pick the requested value
  always_comb begin
    prod_fix = neg_res_i ? -prod_i : prod_i;
    quo_fix  = neg_res_i ? -quo_i  : quo_i;
    rem_fix  = neg_rem_i ? -rem_i  : rem_i;
    result_o = '0;
    if (funct_i[2]) begin
      // funct3 bit 1 separates REM/REMU from DIV/DIVU
      result_o = funct_i[1] ? rem_fix : quo_fix;
    end else if (funct_i == MDU_MUL) begin
      result_o = prod_fix[XLEN-1:0];
    end else begin
      result_o = prod_fix[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/exu_mdu.sv
// Iterative multiply/divide unit. Radix-2 shift-add multiply and restoring
// divide, one bit per cycle, on unsigned magnitudes; divide-by-zero and
// signed overflow resolve at accept with single-cycle latency.
module exu_mdu
  import exu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MDU_FUNCT_WIDTH-1:0] funct,
  input  logic [XLEN-1:0]            src1,
  input  logic [XLEN-1:0]            src2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            result
);

  localparam int              CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e                 state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [MDU_FUNCT_WIDTH-1:0] funct_q;
  logic [XLEN-1:0]            opnd_q;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]          acc_q;      // product, or quotient in the low half
  logic [XLEN-1:0]            rem_q;      // partial remainder
  logic                       neg_res_q;
  logic                       neg_rem_q;
  logic [XLEN-1:0]            result_q;

  // Accept-side decode
  logic            s1_signed, s2_signed, s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_d;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   div_rem_d;
  logic [XLEN-1:0]   div_quo_d;
  logic [XLEN-1:0]   fix_result;

  assign in_ready  = (state_q == MDU_ST_IDLE);
  assign out_valid = (state_q == MDU_ST_DONE);
  assign result    = result_q;

  // Operand signedness, magnitudes and special-case detection at accept
  always_comb begin
    s1_signed = (funct == MDU_MULH) || (funct == MDU_MULHSU) ||
                (funct == MDU_DIV)  || (funct == MDU_REM);
    s2_signed = (funct == MDU_MULH) || (funct == MDU_DIV) || (funct == MDU_REM);
    s1_neg    = s1_signed && src1[XLEN-1];
    s2_neg    = s2_signed && src2[XLEN-1];
    mag1      = s1_neg ? -src1 : src1;
    mag2      = s2_neg ? -src2 : src2;
    is_div    = funct[2];
    div_zero  = is_div && (src2 == '0);
    div_ovf   = ((funct == MDU_DIV) || (funct == MDU_REM)) &&
                (src1 == XMIN) && (src2 == '1);
    special   = div_zero || div_ovf;
    if (div_zero) begin
      special_res = funct[1] ? src1 : '1;
    end else begin
      special_res = funct[1] ? '0 : XMIN;
    end
  end

  // One multiply step and one restoring-divide step per cycle
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // When the subtraction is kept the true difference is below 2^XLEN
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    div_rem_d = div_ge ? div_diff : div_shift[XLEN-1:0];
    div_quo_d = {acc_q[XLEN-2:0], div_ge};
  end

  exu_mdu_fixup #(.XLEN(XLEN)) u_fixup (
    .prod_i    (mul_acc_d),
    .quo_i     (div_quo_d),
    .rem_i     (div_rem_d),
    .neg_res_i (neg_res_q),
    .neg_rem_i (neg_rem_q),
    .funct_i   (funct_q),
    .result_o  (fix_result)
  );

  // Control FSM with counter, iteration registers and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MDU_ST_IDLE;
      cnt_q     <= '0;
      funct_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MDU_ST_IDLE: begin
          if (in_valid) begin
            funct_q   <= funct;
            cnt_q     <= '0;
            opnd_q    <= is_div ? mag2 : mag1;
            acc_q     <= is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            rem_q     <= '0;
            neg_res_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            if (special) begin
              result_q <= special_res;
              state_q  <= MDU_ST_DONE;
            end else begin
              state_q  <= MDU_ST_CALC;
            end
          end
        end
        MDU_ST_CALC: begin
          if (funct_q[2]) begin
            acc_q <= {{XLEN{1'b0}}, div_quo_d};
            rem_q <= div_rem_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          if (cnt_q == CNT_LAST) begin
            result_q <= fix_result;
            state_q  <= MDU_ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        MDU_ST_DONE: begin
          if (out_ready) begin
            state_q <= MDU_ST_IDLE;
          end
        end
        default: state_q <= MDU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu at XLEN=32: vector table plus backpressure,
// flush and mid-operation reset sequences.
module tb_exu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct = 3'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  exu_mdu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency from the accept cycle, check, handshake
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int edges;
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; funct = f; src1 = a; src2 = b;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_latency"}, edges, lat);
    check({name, "_result"}, result, exp);
    $display("op %s funct=%0d a=%h b=%h result=%h latency=%0d", name, f, a, b, result, edges);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_post_ready"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int seen;
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[13] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[14] = '{3'd5, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33};
    vecs[15] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};

    // Reset state
    #23;
    check("reset_state", {29'd0, in_ready, out_valid, |result}, 32'd4);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: hold the result for 5 cycles, then a new request is accepted
    in_valid = 1'b1; funct = 3'd5; src1 = 32'd100; src2 = 32'd7;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin tick(); edges++; end
    check("bp_latency", edges, 33);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), {result[29:0], in_ready, out_valid}, {30'd14, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    in_valid = 1'b1; funct = 3'd0; src1 = 32'd3; src2 = 32'd4;
    tick();
    out_ready = 1'b0;
    check("bp_after_hs", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    in_valid = 1'b0;
    check("bp_new_accept", {31'd0, in_ready}, 32'd0);
    edges = 2;
    while (!out_valid && edges < 100) begin tick(); edges++; end
    check("bp_new_result", result, 32'd12);
    $display("op backpressure result=%h", result);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Flush at CALC count 10
    in_valid = 1'b1; funct = 3'd0; src1 = 32'd9; src2 = 32'd9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_no_valid", seen, 0);
    $display("op flush out_valid_pulses=%0d", seen);

    // Reset at CALC count 20, outputs clear before the next edge
    in_valid = 1'b1; funct = 3'd0; src1 = 32'd7; src2 = 32'hFFFFFFFD;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #2 rst = 1'b0;
    #1;
    check("async_reset", {in_ready, out_valid, result[29:0]}, 32'h80000000);
    check("async_reset_result", result, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    $display("op async_reset done");
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
